// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller:
// FSM state, forwarding-select codes and the shadow-stage record.
package hazard_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int MD_LAT_DEFAULT = 4;
  localparam int CNT_W          = 4;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       gpr_wr;
    logic       mtr;
  } stage_t;

  // True when a shadow stage will write a real (non-zero) register.
  function automatic logic writes_reg(input stage_t s);
    return s.valid && s.gpr_wr && (s.rd != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage instruction fields in, pipeline steering controls out.
// master = the pipeline datapath side, slave = hazard_ctrl.
interface hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] id_rd;
  logic       id_GPRWr;
  logic       id_MTR;
  logic       id_md;
  logic       br_taken;

  logic       o_pc_wr;
  logic       o_ifid_wr;
  logic       o_ifid_flush;
  logic       o_idex_bubble;
  logic [1:0] o_fwdA;
  logic [1:0] o_fwdB;
  logic       o_md_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_GPRWr, id_MTR, id_md, br_taken,
    input  o_pc_wr, o_ifid_wr, o_ifid_flush, o_idex_bubble, o_fwdA, o_fwdB, o_md_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, id_rd, id_GPRWr, id_MTR, id_md, br_taken,
    output o_pc_wr, o_ifid_wr, o_ifid_flush, o_idex_bubble, o_fwdA, o_fwdB, o_md_busy
  );
endinterface

// File: rtl/hazard_ctrl_md_timer.sv
// Down-counter timing the multiply/divide occupancy of EX.
// Loads on issue, decrements while waiting, holds at zero.
module md_timer
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stall, multi-cycle
// multiply/divide wait, taken-branch flush and EX operand forwarding.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  stage_t     id_p;
  stage_t     ex_p0;
  stage_t     mem_p1;
  stage_t     wb_p2;
  state_t     state;
  logic       load_use;
  logic       issue;
  logic       md_start;
  logic       md_zero;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       unused_wb;

  // Forward from the youngest older producer; EX beats MEM.
  function automatic logic [1:0] fwd_sel(input stage_t ex, input stage_t mem,
                                         input logic [4:0] src);
    if (writes_reg(ex) && (ex.rd == src)) begin
      return FWD_EXMEM;
    end else if (writes_reg(mem) && (mem.rd == src)) begin
      return FWD_MEMWB;
    end
    return FWD_RF;
  endfunction

  always_comb begin
    id_p.valid  = bus.id_valid;
    id_p.rd     = bus.id_rd;
    id_p.gpr_wr = bus.id_GPRWr;
    id_p.mtr    = bus.id_MTR;
  end

  always_comb begin
    load_use = ex_p0.valid && ex_p0.mtr && writes_reg(ex_p0) &&
               ((ex_p0.rd == bus.id_rs) ||
                (bus.id_uses_rt && (ex_p0.rd == bus.id_rt)));
    issue    = bus.id_valid && !load_use && (state == RUN) && !bus.br_taken;
    md_start = issue && bus.id_md;
  end

  // ID -> EX -> MEM -> WB shadow shift; only the valid bits are reset.
  always_ff @(posedge clk) begin
    ex_p0        <= id_p;
    ex_p0.valid  <= issue;
    mem_p1       <= ex_p0;
    wb_p2        <= mem_p1;
    if (rst) begin
      ex_p0.valid  <= 1'b0;
      mem_p1.valid <= 1'b0;
      wb_p2.valid  <= 1'b0;
    end
  end

  // WB is tracked for completeness but nothing forwards from it.
  assign unused_wb = ^wb_p2;

  md_timer u_md_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (md_start),
    .load_val (CNT_W'(MD_LAT - 1)),
    .dec      (state == MD_WAIT),
    .zero     (md_zero)
  );

  // FSM and registered forwarding selects for the instruction entering EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else begin
      fwd_a <= issue ? fwd_sel(ex_p0, mem_p1, bus.id_rs) : FWD_RF;
      fwd_b <= (issue && bus.id_uses_rt) ? fwd_sel(ex_p0, mem_p1, bus.id_rt) : FWD_RF;
      case (state)
        RUN:     if (md_start) state <= MD_WAIT;
        MD_WAIT: if (md_zero)  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Priority: reset, taken branch, multiply/divide wait, load-use, normal flow.
  always_comb begin
    bus.o_pc_wr       = 1'b1;
    bus.o_ifid_wr     = 1'b1;
    bus.o_ifid_flush  = 1'b0;
    bus.o_idex_bubble = 1'b0;
    if (rst) begin
      bus.o_pc_wr       = 1'b0;
      bus.o_ifid_wr     = 1'b0;
      bus.o_ifid_flush  = 1'b1;
      bus.o_idex_bubble = 1'b1;
    end else if (bus.br_taken) begin
      bus.o_ifid_flush  = 1'b1;
      bus.o_idex_bubble = 1'b1;
    end else if ((state == MD_WAIT) || load_use) begin
      bus.o_pc_wr       = 1'b0;
      bus.o_ifid_wr     = 1'b0;
      bus.o_idex_bubble = 1'b1;
    end
  end

  assign bus.o_md_busy = !rst && (state == MD_WAIT);
  assign bus.o_fwdA    = fwd_a;
  assign bus.o_fwdB    = fwd_b;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a stimulus task predicts each cycle's
// controls from an instruction-level model; a monitor compares them.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MD_LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.MD_LAT(MD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    logic       pc_wr;
    logic       ifid_wr;
    bit         ifid_dc;
    logic       flush;
    logic       bubble;
    logic       busy;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       wr;
    bit       mtr;
  } instr_t;

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc   = 0;

  instr_t   m_ex, m_mem;
  int       md_left;
  bit [1:0] m_fa, m_fb;

  function automatic bit [1:0] fwd_of(input bit [4:0] src);
    if (src == 0) return 2'b00;
    if (m_ex.valid && m_ex.wr && m_ex.rd == src) return 2'b01;
    if (m_mem.valid && m_mem.wr && m_mem.rd == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic step(input bit r, input bit v, input bit [4:0] rs, input bit [4:0] rt,
                      input bit [4:0] rd, input bit urt, input bit wr, input bit mtr,
                      input bit md, input bit br);
    exp_t     e;
    bit       lu, iss;
    bit [1:0] na, nb;
    @(posedge clk);
    #2;
    rst = r;
    bus.id_valid = v; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_uses_rt = urt; bus.id_GPRWr = wr; bus.id_MTR = mtr;
    bus.id_md = md; bus.br_taken = br;
    cyc++;

    lu  = m_ex.valid && m_ex.mtr && m_ex.wr && m_ex.rd != 0 &&
          (m_ex.rd == rs || (urt && m_ex.rd == rt));
    iss = !r && v && !lu && md_left == 0 && !br;

    e.cyc = cyc; e.fa = m_fa; e.fb = m_fb; e.ifid_dc = 1'b0;
    e.busy = !r && md_left > 0;
    if (r) begin
      e.pc_wr = 0; e.ifid_wr = 0; e.flush = 1; e.bubble = 1;
    end else if (br) begin
      e.pc_wr = 1; e.ifid_wr = 1; e.ifid_dc = 1'b1; e.flush = 1; e.bubble = 1;
    end else if (md_left > 0 || lu) begin
      e.pc_wr = 0; e.ifid_wr = 0; e.flush = 0; e.bubble = 1;
    end else begin
      e.pc_wr = 1; e.ifid_wr = 1; e.flush = 0; e.bubble = 0;
    end
    sb.push_back(e);

    if (r) begin
      m_ex.valid = 0; m_mem.valid = 0; md_left = 0; m_fa = 0; m_fb = 0;
    end else begin
      na = iss ? fwd_of(rs) : 2'b00;
      nb = (iss && urt) ? fwd_of(rt) : 2'b00;
      m_fa = na; m_fb = nb;
      if (md_left > 0) md_left--;
      if (iss && md) md_left = MD_LAT;
      m_mem = m_ex;
      m_ex  = '{valid: iss, rd: rd, wr: wr, mtr: mtr};
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        ok = (bus.o_pc_wr === e.pc_wr) && (e.ifid_dc || bus.o_ifid_wr === e.ifid_wr) &&
             (bus.o_ifid_flush === e.flush) && (bus.o_idex_bubble === e.bubble) &&
             (bus.o_md_busy === e.busy) && (bus.o_fwdA === e.fa) && (bus.o_fwdB === e.fb);
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("FAIL ctrl cyc=%0d got pc_wr=%b ifid_wr=%b flush=%b bubble=%b busy=%b fwdA=%b fwdB=%b want pc_wr=%b ifid_wr=%b%s flush=%b bubble=%b busy=%b fwdA=%b fwdB=%b",
                   e.cyc, bus.o_pc_wr, bus.o_ifid_wr, bus.o_ifid_flush, bus.o_idex_bubble,
                   bus.o_md_busy, bus.o_fwdA, bus.o_fwdB, e.pc_wr, e.ifid_wr,
                   e.ifid_dc ? "(any)" : "", e.flush, e.bubble, e.busy, e.fa, e.fb);
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1;
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_uses_rt = 0; bus.id_GPRWr = 0; bus.id_MTR = 0; bus.id_md = 0; bus.br_taken = 0;
    m_ex = '{default: 0}; m_mem = '{default: 0}; md_left = 0; m_fa = 0; m_fb = 0;
    @(posedge clk);

    // reset held: forced controls, cleared forwards
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 2, 3, 1, 1, 0, 0, 0);

    // load-use: lw r5, then consumer rs=5 stalls once, issues with MEM/WB forward
    step(0, 1, 0, 0, 5, 0, 1, 1, 0, 0);
    step(0, 1, 5, 0, 7, 0, 1, 0, 0, 0);
    step(0, 1, 5, 0, 7, 0, 1, 0, 0, 0);
    idle(); idle();

    // ALU chain: add r3; sub rs=3 -> EX/MEM; third rt=3 -> MEM/WB
    step(0, 1, 1, 2, 3, 1, 1, 0, 0, 0);
    step(0, 1, 3, 4, 8, 1, 1, 0, 0, 0);
    step(0, 1, 9, 3, 10, 1, 1, 0, 0, 0);
    idle(); idle();

    // register 0 producer/consumer: no stall, no forward
    step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 11, 1, 1, 0, 0, 0);
    idle(); idle();

    // multiply: busy MD_LAT cycles, then RUN
    step(0, 1, 1, 2, 12, 1, 1, 0, 1, 0);
    repeat (MD_LAT + 1) step(0, 1, 12, 0, 13, 0, 1, 0, 0, 0);
    idle(); idle();

    // branch together with load-use: flush wins, no stall after
    step(0, 1, 0, 0, 6, 0, 1, 1, 0, 0);
    step(0, 1, 6, 0, 14, 0, 1, 0, 0, 1);
    step(0, 1, 6, 0, 14, 0, 1, 0, 0, 0);
    idle(); idle();

    // branch during MD_WAIT does not reload the counter
    step(0, 1, 1, 2, 15, 1, 1, 0, 1, 0);
    step(0, 1, 1, 2, 16, 1, 1, 0, 0, 0);
    step(0, 1, 1, 2, 16, 1, 1, 0, 0, 1);
    repeat (MD_LAT) step(0, 1, 1, 2, 16, 1, 1, 0, 0, 0);
    idle();

    // reset in the 2nd MD_WAIT cycle abandons the operation
    step(0, 1, 1, 2, 17, 1, 1, 0, 1, 0);
    step(0, 1, 1, 2, 18, 1, 1, 0, 0, 0);
    step(1, 1, 1, 2, 18, 1, 1, 0, 0, 0);
    step(0, 1, 1, 2, 18, 1, 1, 0, 0, 0);
    idle(); idle();

    // randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 99) < 85,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)),
           $urandom_range(0, 99) < 80,
           $urandom_range(0, 99) < 30,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 7) == 0);
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain got %0d pending entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_LAT, default 4: EX-stage occupancy, in cycles (2..15), of a multiply/divide instruction.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 id_valid  in  1  the ID stage holds a real instruction.
REQ-005 id_rs, id_rt  in  5 each  source registers of the ID instruction.
REQ-006 id_uses_rt  in  1  the ID instruction reads rt.
REQ-007 id_rd  in  5  destination register of the ID instruction.
REQ-008 id_GPRWr, id_MTR  in  1 each  the ID instruction writes the GPR file / loads from memory.
REQ-009 id_md  in  1  the ID instruction is a multi-cycle multiply/divide.
REQ-010 br_taken  in  1  a branch resolved taken in EX this cycle.
REQ-011 o_pc_wr  out  1  PC load enable.
REQ-012 o_ifid_wr  out  1  IF/ID write enable.
REQ-013 o_ifid_flush  out  1  zero the IF/ID register.
REQ-014 o_idex_bubble  out  1  drive a zero signal byte into ID/EX (NOP).
REQ-015 o_fwdA, o_fwdB  out  2 each  EX operand select: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
REQ-016 o_md_busy  out  1  the multiply/divide unit is occupied.

Function
REQ-017 Block SHALL keep shadow stages EX, MEM and WB, each holding {valid, rd, GPRWr, MTR}.
REQ-018 Shadow stages SHALL shift every cycle: EX<-ID fields if the ID instruction issues, else valid=0.
REQ-019 Issue condition: id_valid and no load-use hazard and state RUN and !br_taken.
REQ-020 Load-use hazard: EX.valid && EX.MTR && EX.GPRWr && EX.rd!=0 && (EX.rd==id_rs || (id_uses_rt && EX.rd==id_rt)).
REQ-021 On a load-use hazard (without br_taken): pc_wr=0, ifid_wr=0, idex_bubble=1 for exactly one cycle.
REQ-022 FSM states SHALL be RUN and MD_WAIT.
REQ-023 When a multiply/divide (id_md) issues: transition RUN->MD_WAIT, counter<=MD_LAT-1.
REQ-024 Each cycle in MD_WAIT: counter decrements; pc_wr=0, ifid_wr=0, idex_bubble=1; o_md_busy=1.
REQ-025 In MD_WAIT, when the counter reaches 0 the FSM SHALL return to RUN on the next edge.
REQ-026 br_taken SHALL have highest priority: pc_wr=1, ifid_flush=1, idex_bubble=1, no issue.
REQ-027 A br_taken arriving during MD_WAIT SHALL NOT abort or reload the counter.
REQ-028 No hazard, RUN, no branch: pc_wr=1, ifid_wr=1, ifid_flush=0, idex_bubble=0.
REQ-029 o_fwdA/B SHALL be registered on issue; they apply to the instruction then in EX.
REQ-030 fwdA=01 if the old EX stage (valid, GPRWr, rd!=0) has rd==id_rs.
REQ-031 Otherwise fwdA=10 if the old MEM stage matches id_rs under the same conditions; otherwise 00. fwdB is identical on id_rt, and 00 if !id_uses_rt.
REQ-032 When no instruction issues, o_fwdA/B SHALL register 00.
REQ-033 Register 0 SHALL never produce a hazard or a forward.

Reset
REQ-034 With rst high at posedge: all shadow valid=0, state RUN, counter=0, fwdA/B=00.
REQ-035 While rst is high: o_pc_wr=0, o_ifid_wr=0, o_ifid_flush=1, o_idex_bubble=1, o_md_busy=0.
REQ-036 Reset asserted in MD_WAIT SHALL abandon the operation and return to RUN.

Structure
REQ-037 Package hazard_pkg SHALL hold: the state type, the FWD_RF/FWD_EXMEM/FWD_MEMWB encodings, and the MD_LAT default.
REQ-038 Sub-module md_timer (load, decrement, zero flag) SHALL hold the MD_WAIT counter; everything else stays in hazard_ctrl.

Verification
REQ-039 Load-use: lw rd=5 issues, next ID instruction has rs=5 -> one cycle pc_wr=0/bubble=1, then issue with fwdA=10.
REQ-040 ALU chain: add rd=3, then sub rs=3 -> no stall, fwdA=01; a third instruction with rt=3 gets fwdB=10.
REQ-041 rd=0 producer, consumer rs=0 -> no stall, fwdA=00.
REQ-042 MD_LAT=4 mult issues -> o_md_busy high 4 cycles, ID stalled 4 cycles, RUN on the 5th.
REQ-043 br_taken together with a load-use hazard -> pc_wr=1, ifid_flush=1, bubble=1, no stall cycle after.
REQ-044 rst raised in the 2nd MD_WAIT cycle -> next cycle RUN, md_busy=0, all fwd=00.
